// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/enable controller for a five-stage pipeline with data-wait and halt tracking
module pipeline_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_req,
    input  logic        halt,
    input  logic        ld_in_ex,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        br_taken,
    input  logic        jmp_id,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        halted,
    output logic [15:0] stall_cnt
);
    typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;
    state_t state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [8:0] ctl;
    logic hold, dfrz, lu;
    always_comb begin
        hold = state_q == HALT || halt;
        dfrz = (state_q == DWAIT || mem_req) && !dhit;
        lu = ld_in_ex && ex_rt != 5'd0 && (ex_rt == id_rs || ex_rt == id_rt);
        // {pc_en, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush}
        ctl = RST      ? 9'b0_0000_1111 :
              hold     ? 9'b0_0000_0000 :
              dfrz     ? 9'b0_0000_0000 :
              br_taken ? 9'b1_1111_1110 :
              lu       ? 9'b0_0111_0100 :
              jmp_id   ? 9'b1_1111_1000 :
              !ihit    ? 9'b0_1111_1000 :
                         9'b1_1111_0000;
        state_d = RST ? RUN : hold ? HALT : dfrz ? DWAIT : RUN;
        stall_cnt_d = RST ? 16'd0 :
                      (!ctl[8] && !hold && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end
    always_ff @(posedge CLK) begin
        state_q <= state_d;
        stall_cnt_q <= stall_cnt_d;
    end
    assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, exmem_flush, memwb_flush} = ctl;
    assign halted = state_q == HALT;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: randomized and directed scoreboard bench for pipeline_ctrl against a rule-level model
module tb_pipeline_ctrl;
    logic CLK = 1'b0, RST = 1'b1, ihit = 1'b1, dhit = 1'b0, mem_req = 1'b0, halt = 1'b0;
    logic ld_in_ex = 1'b0, br_taken = 1'b0, jmp_id = 1'b0;
    logic [4:0] ex_rt = '0, id_rs = '0, id_rt = '0;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
    logic [15:0] stall_cnt;

    typedef struct packed {
        logic pc, e_ifid, e_idex, e_exmem, e_memwb, f_ifid, f_idex, f_exmem, f_memwb;
    } ctl_t;
    typedef struct packed {
        ctl_t ctl;
        logic h;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int total = 0, bad = 0;
    bit m_halted = 1'b0, m_wait = 1'b0;
    int m_cnt = 0;
    bit done = 1'b0;

    pipeline_ctrl dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req), .halt(halt),
        .ld_in_ex(ld_in_ex), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .br_taken(br_taken), .jmp_id(jmp_id), .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .memwb_flush(memwb_flush), .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    // Reference: decide which rule wins this cycle, predict outputs, then advance the abstract state
    task automatic push_expect();
        exp_t e;
        ctl_t c;
        bit use_hz;
        c = '{pc:1, e_ifid:1, e_idex:1, e_exmem:1, e_memwb:1, f_ifid:0, f_idex:0, f_exmem:0, f_memwb:0};
        use_hz = ld_in_ex && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
        if (RST) c = '{pc:0, e_ifid:0, e_idex:0, e_exmem:0, e_memwb:0, f_ifid:1, f_idex:1, f_exmem:1, f_memwb:1};
        else if (m_halted || halt || ((m_wait || mem_req) && !dhit)) c = '0;
        else if (br_taken) begin
            c.f_ifid = 1; c.f_idex = 1; c.f_exmem = 1;
        end else if (use_hz) begin
            c.pc = 0; c.e_ifid = 0; c.f_idex = 1;
        end else if (jmp_id) c.f_ifid = 1;
        else if (!ihit) begin
            c.pc = 0; c.f_ifid = 1;
        end
        e.ctl = c;
        e.h = m_halted;
        e.cnt = 16'(m_cnt);
        sb.push_back(e);
        if (RST) begin
            m_halted = 0; m_wait = 0; m_cnt = 0;
        end else if (m_halted || halt) m_halted = 1;
        else begin
            m_wait = (m_wait || mem_req) && !dhit;
            if (!c.pc && m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic cyc(input bit r, input bit ih, input bit dh, input bit mr, input bit hl,
                       input bit ld, input int ert, input int rs, input int rt, input bit br, input bit jp);
        @(posedge CLK);
        #1;
        RST = r; ihit = ih; dhit = dh; mem_req = mr; halt = hl; ld_in_ex = ld;
        ex_rt = 5'(ert); id_rs = 5'(rs); id_rt = 5'(rt); br_taken = br; jmp_id = jp;
        push_expect();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                total += 3;
                if ({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, memwb_flush} !== e.ctl) begin
                    bad++;
                    $display("FAIL ctl t=%0t got=%b want=%b", $time,
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, memwb_flush}, e.ctl);
                end
                if (halted !== e.h) begin
                    bad++;
                    $display("FAIL halted t=%0t got=%b want=%b", $time, halted, e.h);
                end
                if (stall_cnt !== e.cnt) begin
                    bad++;
                    $display("FAIL stall_cnt t=%0t got=%h want=%h", $time, stall_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge CLK);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // data wait 3 cycles then release
        repeat (3) cyc(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // load-use and its ex_rt=0 counterpart
        cyc(0, 1, 0, 0, 0, 1, 5, 5, 7, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 9, 3, 9, 0, 0);
        // branch beats load-use and fetch miss
        cyc(0, 0, 0, 0, 0, 1, 5, 5, 5, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // halt during DWAIT, hold 10 cycles, then reset
        cyc(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        repeat (10) cyc(0, 0, 1, 1, 0, 1, 4, 4, 4, 1, 1);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // reset mid-DWAIT
        repeat (2) cyc(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 127) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        // counter saturation
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (70000) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        repeat (3) @(negedge CLK);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001: Clocking SHALL be one clock; reset is synchronous and active-high; port names are CLK and RST.
REQ-002: CLK  in  1  rising-edge clock for all state.
REQ-003: RST  in  1  synchronous active-high reset.
REQ-004: ihit  in  1  instruction fetch completes this cycle.
REQ-005: dhit  in  1  data access completes this cycle.
REQ-006: mem_req  in  1  MEM stage holds dREN or dWEN.
REQ-007: halt  in  1  halt instruction at MEM/WB register output.
REQ-008: ld_in_ex  in  1  ID/EX memToReg asserted (load in EX).
REQ-009: ex_rt  in  5  ID/EX destination register number.
REQ-010: id_rs, id_rt  in  5 each  IF/ID source register numbers.
REQ-011: br_taken  in  1  taken branch or jr resolved in EX/MEM.
REQ-012: jmp_id  in  1  j/jal decoded in ID.
REQ-013: pc_en  out  1  PC loads next value.
REQ-014: ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipe register enable.
REQ-015: ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  pipe register clears to bubble on next edge; flush overrides en.
REQ-016: halted  out  1  sticky processor-halted flag.
REQ-017: stall_cnt  out  16  count of cycles with pc_en=0 while not halted.

Function
REQ-018: FSM states SHALL be RUN, DWAIT, HALT; all outputs except halted and stall_cnt are combinational from state and inputs.
REQ-019: Priority SHALL be RST > HALT > data wait > br_taken > load-use > jmp_id > fetch miss; only the highest active rule drives outputs.
REQ-020: Default (RUN, no rule active): pc_en and all four en = 1, all flush = 0.
REQ-021: HALT state or halt=1: pc_en and all en = 0, all flush = 0; next state HALT; halted = 1 from the following cycle until RST.
REQ-022: RUN with mem_req=1 and dhit=0: pc_en and all en = 0, all flush = 0; next state DWAIT.
REQ-023: DWAIT with dhit=0: same freeze as REQ-022; remain DWAIT regardless of other inputs (except halt).
REQ-024: DWAIT with dhit=1: apply REQ-020 (then lower-priority rules evaluated normally); next state RUN.
REQ-025: RUN with mem_req=1 and dhit=1: no freeze; remain RUN.
REQ-026: br_taken=1: pc_en=1, ifid_flush=idex_flush=exmem_flush=1, memwb_en=1, memwb_flush=0.
REQ-027: Load-use (ld_in_ex=1, ex_rt!=0, ex_rt==id_rs or ex_rt==id_rt): pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; single cycle, no state change.
REQ-028: jmp_id=1: pc_en=1, ifid_flush=1, remaining en = 1.
REQ-029: Fetch miss (ihit=0, no higher rule): pc_en=0, ifid_flush=1, idex_en=exmem_en=memwb_en=1.
REQ-030: ex_rt=0 SHALL never trigger load-use.
REQ-031: stall_cnt SHALL increment by 1 on each edge where pc_en=0 and state!=HALT and halt=0; saturates at 0xFFFF, never wraps.

Reset
REQ-032: RST=1 SHALL force next state RUN, halted=0, stall_cnt=0x0000 on the edge, including from DWAIT or HALT.
REQ-033: While RST=1: pc_en and all en = 0, all flush = 1.
REQ-034: First cycle after RST deasserts SHALL follow REQ-019 from RUN.

Verification
REQ-035: RUN, mem_req=1, dhit=0 for 3 cycles then dhit=1 -> 3 cycles all en=0, DWAIT; 4th cycle all en=1, state RUN; stall_cnt +3.
REQ-036: ld_in_ex=1, ex_rt=5, id_rs=5, ihit=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; same with ex_rt=0 -> default outputs.
REQ-037: br_taken=1 with simultaneous load-use and ihit=0 -> pc_en=1, ifid/idex/exmem_flush=1; stall_cnt unchanged.
REQ-038: halt=1 during DWAIT -> all en=0, halted=1 next cycle, stays 1 for 10 cycles with stall_cnt frozen; RST -> halted=0, stall_cnt=0.
REQ-039: ihit=0 held 70000 cycles -> stall_cnt saturates at 0xFFFF; ifid_flush=1 every cycle.
REQ-040: RST asserted mid-DWAIT -> outputs per REQ-033; next cycle state RUN with default outputs.
